shft_left: RTL and testbench
============================

Name: shft_left

Overview:
- Branch-offset left shifter in the pipelined processor datapath.
- Takes the sign-extended offset (in_se) and multiplies it by two with a logical left shift by one.
- Feeds the branch-target adder (adder2).
- Provides a combinational result for same-cycle use and a registered, valid-qualified copy for the next pipeline stage.

Parameters:
- WIDTH, 6, data width of in_se and all shifted outputs.
- SHAMT, 1, fixed left-shift amount; legal range 1..WIDTH-1.

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- in_se  input  WIDTH  sign-extended offset from the extend unit.
- in_valid  input  1  in_se is meaningful this cycle.
- out_adder2  output  WIDTH  combinational in_se << SHAMT, to adder2.
- ovf  output  1  combinational; 1 when any bit shifted out of the top is 1.
- out_adder2_q  output  WIDTH  registered out_adder2.
- ovf_q  output  1  registered ovf.
- out_valid  output  1  registered in_valid; qualifies out_adder2_q and ovf_q.

Behaviour:
- Combinational path, zero latency, no dependence on clk or rst_n:
  - out_adder2 = {in_se[WIDTH-1-SHAMT:0], SHAMT zeros}; the top SHAMT bits are discarded and no wrap occurs.
  - ovf = OR of in_se[WIDTH-1 : WIDTH-SHAMT].
  - Both outputs update in the same simulation time step as in_se, including at time 0.
  - in_valid has no effect on this path.
- Registered path, 1-cycle latency:
  - On each rising clk edge with rst_n=1: out_adder2_q <= out_adder2, ovf_q <= ovf, out_valid <= in_valid.
  - When in_valid=0, out_adder2_q and ovf_q hold their previous values; only out_valid is updated, to 0.
  - Back-to-back valid inputs produce back-to-back valid outputs, one per cycle.
  - There is no stall or backpressure.
- Reset:
  - rst_n=0 asynchronously forces out_adder2_q=0, ovf_q=0 and out_valid=0 immediately, without waiting for a clock edge.
  - These values are held while rst_n=0.
  - Reset does not affect out_adder2 or ovf.
  - Reset during a valid transfer discards that transfer.
  - The first capture after reset is on the first rising edge after rst_n returns to 1.
- X/unknown in_se bits propagate only to the corresponding shifted bit positions; the inserted LSB zeros are always 0.
- Arithmetic: this is a logical shift only; there is no sign preservation beyond the truncation.

Test Plan:
- Combinational known values, changing in_se every 20 time units with no clock activity:
  - in_se=000110 -> out_adder2=001100, ovf=0.
  - in_se=000100 -> out_adder2=001000, ovf=0.
  - in_se=000000 -> out_adder2=000000, ovf=0.
- Overflow: in_se=100001 -> out_adder2=000010, ovf=1; in_se=011111 -> out_adder2=111110, ovf=0.
- Registered path: assert rst_n, then in_se=000110 with in_valid=1 at edge N -> after edge N, out_adder2_q=001100 and out_valid=1. At edge N+1 with in_valid=0 -> out_valid=0 and out_adder2_q holds 001100.
- Async reset mid-operation: out_valid=1, out_adder2_q=001000; drop rst_n between clock edges -> out_adder2_q=000000, ovf_q=0, out_valid=0 immediately. Meanwhile out_adder2 still tracks in_se.
- Streaming: 000001, 000010, 000100, 001000 with in_valid=1 on consecutive edges -> out_adder2_q = 000010, 000100, 001000, 010000 on successive cycles, out_valid held at 1.
- Exhaustive: all 64 in_se values -> out_adder2 == (in_se*2) mod 64 and ovf == in_se[5].

Source files
------------

// File: rtl/shft_left.sv
// Branch-offset left shifter: multiplies the sign-extended offset by 2^SHAMT for the branch-target adder.
// Provides a zero-latency combinational result and a registered, valid-qualified copy.
module shft_left #(
  parameter int WIDTH = 6,
  parameter int SHAMT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_se,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out_adder2,
  output logic             ovf,
  output logic [WIDTH-1:0] out_adder2_q,
  output logic             ovf_q,
  output logic             out_valid
);

  logic [WIDTH-1:0] out_adder2_d;
  logic             ovf_d;
  logic             out_valid_d;
  logic             out_valid_q;

  // Per-bit wiring keeps X confined to its own shifted position; inserted LSBs are hard zeros.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift
    if (gi < SHAMT) begin : g_zero
      assign out_adder2[gi] = 1'b0;
    end else begin : g_move
      assign out_adder2[gi] = in_se[gi-SHAMT];
    end
  end

  assign ovf = |in_se[WIDTH-1 -: SHAMT];

  always_comb begin
    out_adder2_d = out_adder2_q;
    ovf_d        = ovf_q;
    out_valid_d  = in_valid;
    if (in_valid) begin
      out_adder2_d = out_adder2;
      ovf_d        = ovf;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_adder2_q <= '0;
      ovf_q        <= 1'b0;
      out_valid_q  <= 1'b0;
    end else begin
      out_adder2_q <= out_adder2_d;
      ovf_q        <= ovf_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_shft_left.sv
// Directed bench for shft_left: combinational known values, exhaustive sweep, and a
// scoreboard-checked registered path including async reset and streaming.
module tb_shft_left;

  typedef struct packed {
    logic [5:0] d;
    logic       o;
  } exp_t;

  logic       clk;
  logic       clk_en;
  logic       rst_n;
  logic [5:0] in_se;
  logic       in_valid;
  logic [5:0] out_adder2;
  logic       ovf;
  logic [5:0] out_adder2_q;
  logic       ovf_q;
  logic       out_valid;

  int   total;
  int   bad;
  exp_t sb[$];
  logic [5:0] last_d;
  logic       last_o;

  shft_left #(.WIDTH(6), .SHAMT(1)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_se(in_se),
    .in_valid(in_valid),
    .out_adder2(out_adder2),
    .ovf(ovf),
    .out_adder2_q(out_adder2_q),
    .ovf_q(ovf_q),
    .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic exp_t model(input logic [5:0] v);
    int p;
    exp_t e;
    p   = int'(v) * 2;
    e.d = 6'(p % 64);
    e.o = (int'(v) >= 32);
    return e;
  endfunction

  task automatic chk6(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_valid(input logic [5:0] v);
    in_se    = v;
    in_valid = 1'b1;
    sb.push_back(model(v));
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    chk1({tag, "_valid"}, out_valid, 1'b1);
    total++;
    assert (sb.size() > 0) else begin
      bad++;
      $error("FAIL %s_sb: observed=empty expected=entry", tag);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk6({tag, "_q"}, out_adder2_q, e.d);
      chk1({tag, "_ovf_q"}, ovf_q, e.o);
      last_d = e.d;
      last_o = e.o;
      $display("txn %s: in->q=%b ovf_q=%b", tag, out_adder2_q, ovf_q);
    end
  endtask

  logic [5:0] comb_in  [5] = '{6'b000110, 6'b000100, 6'b000000, 6'b100001, 6'b011111};
  logic [5:0] comb_out [5] = '{6'b001100, 6'b001000, 6'b000000, 6'b000010, 6'b111110};
  logic       comb_ovf [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [5:0] stream   [4] = '{6'b000001, 6'b000010, 6'b000100, 6'b001000};

  initial begin
    exp_t e;
    logic v;
    total    = 0;
    bad      = 0;
    clk_en   = 1'b0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_se    = 6'b000110;
    last_d   = '0;
    last_o   = 1'b0;

    // reset state and time-0 combinational path
    #1;
    chk6("rst_q", out_adder2_q, 6'b000000);
    chk1("rst_ovf_q", ovf_q, 1'b0);
    chk1("rst_valid", out_valid, 1'b0);
    chk6("t0_comb", out_adder2, 6'b001100);
    #19;

    // combinational known values, no clock
    for (int i = 0; i < 5; i++) begin
      in_se = comb_in[i];
      #1;
      chk6("comb_out", out_adder2, comb_out[i]);
      chk1("comb_ovf", ovf, comb_ovf[i]);
      $display("txn comb: in=%b out=%b ovf=%b", in_se, out_adder2, ovf);
      #19;
    end

    // exhaustive sweep against the arithmetic model
    for (int i = 0; i < 64; i++) begin
      in_se = 6'(i);
      #1;
      e = model(in_se);
      chk6("exh_out", out_adder2, e.d);
      chk1("exh_ovf", ovf, e.o);
    end
    $display("txn exhaustive: 64 values swept");

    // release reset, start clock
    rst_n  = 1'b1;
    clk_en = 1'b1;
    tick();
    chk1("idle_valid", out_valid, 1'b0);

    drive_valid(6'b000110);
    tick();
    pop_check("reg1");
    in_valid = 1'b0;
    in_se    = 6'b111111;
    tick();
    chk1("hold_valid", out_valid, 1'b0);
    chk6("hold_q", out_adder2_q, 6'b001100);
    chk1("hold_ovf_q", ovf_q, 1'b0);

    // async reset mid-operation
    drive_valid(6'b000100);
    tick();
    pop_check("pre_rst");
    chk6("pre_rst_q", out_adder2_q, 6'b001000);
    #1;
    rst_n = 1'b0;
    #1;
    chk6("arst_q", out_adder2_q, 6'b000000);
    chk1("arst_ovf_q", ovf_q, 1'b0);
    chk1("arst_valid", out_valid, 1'b0);
    in_se = 6'b100001;
    #1;
    chk6("arst_comb", out_adder2, 6'b000010);
    chk1("arst_comb_ovf", ovf, 1'b1);
    in_valid = 1'b1;
    tick();
    chk1("rst_discard_valid", out_valid, 1'b0);
    chk6("rst_discard_q", out_adder2_q, 6'b000000);
    in_valid = 1'b0;
    #1;
    rst_n = 1'b1;
    tick();
    chk1("post_rst_valid", out_valid, 1'b0);
    last_d = '0;
    last_o = 1'b0;

    // back-to-back streaming
    for (int i = 0; i < 4; i++) begin
      drive_valid(stream[i]);
      tick();
      pop_check("stream");
    end
    in_valid = 1'b0;
    tick();
    chk1("stream_end_valid", out_valid, 1'b0);

    // random valid pattern, scoreboard-checked
    for (int i = 0; i < 40; i++) begin
      v = 1'($urandom_range(0, 1));
      if (v) begin
        drive_valid(6'($urandom_range(0, 63)));
      end else begin
        in_valid = 1'b0;
        in_se    = 6'($urandom_range(0, 63));
      end
      tick();
      if (v) begin
        pop_check("rand");
      end else begin
        chk1("rand_idle_valid", out_valid, 1'b0);
        chk6("rand_idle_q", out_adder2_q, last_d);
        chk1("rand_idle_ovf_q", ovf_q, last_o);
      end
    end
    in_valid = 1'b0;

    total++;
    assert (sb.size() == 0) else begin
      bad++;
      $error("FAIL sb_drain: observed=%0d expected=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
